// File: rtl/pll_lock_manager.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable LOCKED, then
// releases the per-domain resets one channel at a time and re-runs on loss.
module pll_lock_manager #(
   parameter int NUM_CH         = 3,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int SETTLE_CYCLES  = 256,
   parameter int STAGGER_CYCLES = 8,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              locked,
   input  logic              restart,
   output logic              pll_rst,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic              ready,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  loss_cnt,
   output logic              timeout_err
);

   localparam logic [2:0] S_RESET     = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_SETTLE    = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   localparam int REL_SPAN = (NUM_CH - 1) * STAGGER_CYCLES;
   localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD   = (SETTLE_CYCLES > REL_SPAN + 1) ? SETTLE_CYCLES : REL_SPAN + 1;
   localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST     = CW'(REL_SPAN);

   logic              locked_m;
   logic              locked_s;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic [2:0]        state_nxt;
   logic              loss_inc;
   logic              timeout_set;
   logic [NUM_CH-1:0] ch_nxt;

   // Next-state decision; RESTART overrides everything, including the loss
   // and timeout bookkeeping of the state it interrupts.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CW'(1);
      loss_inc    = 1'b0;
      timeout_set = 1'b0;
      case (state)
         S_RESET: begin
            if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = S_SETTLE;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_set = 1'b1;
               state_nxt   = S_RESET;
            end
         end
         S_SETTLE: begin
            if (!locked_s)                state_nxt = S_RESET;
            else if (cnt == SETTLE_LAST)  state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (!locked_s) begin
               loss_inc  = 1'b1;
               state_nxt = S_RESET;
            end else if (cnt == REL_LAST) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            cnt_nxt = cnt;
            if (!locked_s) begin
               loss_inc  = 1'b1;
               state_nxt = S_RESET;
            end
         end
         default: state_nxt = S_RESET;
      endcase
      if (restart) begin
         state_nxt   = S_RESET;
         loss_inc    = 1'b0;
         timeout_set = 1'b0;
      end
      if (restart || state_nxt != state) cnt_nxt = '0;
   end

   // Channel i opens i*STAGGER_CYCLES cycles after RELEASE entry.
   always_comb begin
      ch_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_nxt[i] = (state_nxt == S_RUN) ||
                     ((state_nxt == S_RELEASE) && (32'(cnt_nxt) >= 32'(i * STAGGER_CYCLES)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_m    <= 1'b0;
         locked_s    <= 1'b0;
         state       <= S_RESET;
         cnt         <= '0;
         pll_rst     <= 1'b1;
         ch_rst_n    <= '0;
         ready       <= 1'b0;
         loss_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         locked_m <= locked;
         locked_s <= locked_m;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pll_rst  <= (state_nxt == S_RESET);
         ready    <= (state_nxt == S_RUN);
         ch_rst_n <= ch_nxt;
         if (loss_inc && loss_cnt != {CNT_W{1'b1}}) loss_cnt <= loss_cnt + CNT_W'(1);
         if (timeout_set) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Randomised bench for pll_lock_manager; a phase/time-in-phase model derives
// every expected output from the sequencing rules.
module tb_pll_lock_manager;

   localparam int NUM_CH = 3;
   localparam int PRC    = 4;
   localparam int LT     = 32;
   localparam int SC     = 8;
   localparam int ST     = 2;
   localparam int CNT_W  = 4;
   localparam int LOSS_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst_n;
   logic              locked;
   logic              restart;
   logic              pll_rst;
   logic [NUM_CH-1:0] ch_rst_n;
   logic              ready;
   logic [2:0]        state;
   logic [CNT_W-1:0]  loss_cnt;
   logic              timeout_err;

   int checks = 0;
   int errors = 0;

   // Model: phase number, edges since phase entry, counters, LOCKED pipeline.
   int m_phase;
   int m_t;
   int m_loss;
   int m_terr;
   int lq[$];

   pll_lock_manager #(
      .NUM_CH(NUM_CH), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT),
      .SETTLE_CYCLES(SC), .STAGGER_CYCLES(ST), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .locked(locked), .restart(restart),
      .pll_rst(pll_rst), .ch_rst_n(ch_rst_n), .ready(ready), .state(state),
      .loss_cnt(loss_cnt), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs != exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int expectedChannels();
      int n;
      if (m_phase == 4) return (1 << NUM_CH) - 1;
      if (m_phase != 3) return 0;
      n = m_t / ST + 1;
      if (n > NUM_CH) n = NUM_CH;
      return (1 << n) - 1;
   endfunction

   task automatic modelReset();
      m_phase = 0;
      m_t     = 0;
      m_loss  = 0;
      m_terr  = 0;
      lq      = {0, 0};
   endtask

   task automatic enterPhase(input int p);
      m_phase = p;
      m_t     = 0;
   endtask

   task automatic lockLost();
      if (m_loss < LOSS_MAX) m_loss++;
      enterPhase(0);
   endtask

   task automatic modelStep();
      int ls;
      ls = lq.pop_front();
      lq.push_back(int'(locked));
      if (restart) begin
         enterPhase(0);
      end else begin
         case (m_phase)
            0: if (m_t + 1 == PRC) enterPhase(1); else m_t++;
            1: begin
               if (ls != 0)            enterPhase(2);
               else if (m_t + 1 == LT) begin m_terr = 1; enterPhase(0); end
               else                    m_t++;
            end
            2: begin
               if (ls == 0)            enterPhase(0);
               else if (m_t + 1 == SC) enterPhase(3);
               else                    m_t++;
            end
            3: begin
               if (ls == 0)                        lockLost();
               else if (m_t == (NUM_CH - 1) * ST)  enterPhase(4);
               else                                m_t++;
            end
            default: if (ls == 0) lockLost();
         endcase
      end
   endtask

   task automatic checkAll();
      checkOutput("state",       int'(state),       m_phase);
      checkOutput("pll_rst",     int'(pll_rst),     int'(m_phase == 0));
      checkOutput("ch_rst_n",    int'(ch_rst_n),    expectedChannels());
      checkOutput("ready",       int'(ready),       int'(m_phase == 4));
      checkOutput("loss_cnt",    int'(loss_cnt),    m_loss);
      checkOutput("timeout_err", int'(timeout_err), m_terr);
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   task automatic applyStimulus(input logic lk, input logic rs, input int n);
      locked  = lk;
      restart = rs;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous reset: outputs must return without any clock edge.
   task automatic applyReset();
      rst_n = 1'b0;
      #1;
      modelReset();
      checkAll();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int waited;
      rst_n   = 1'b1;
      locked  = 1'b0;
      restart = 1'b0;
      #1;
      modelReset();
      applyReset();

      // Clean start, then timeout loops with LOCKED held low.
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 40);
      applyStimulus(1'b0, 1'b0, 90);

      // Glitch during SETTLE.
      applyReset();
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 30);

      // Repeated run losses drive the loss counter into saturation.
      for (int k = 0; k < 17; k++) begin
         applyStimulus(1'b1, 1'b0, 30);
         applyStimulus(1'b0, 1'b0, 4);
      end

      // RESTART on the edge that sees locked_s fall.
      applyStimulus(1'b1, 1'b0, 30);
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 30);

      // Async reset once channels 0 and 1 are open.
      applyReset();
      locked  = 1'b1;
      restart = 1'b0;
      waited  = 0;
      while (!(m_phase == 3 && expectedChannels() == 3) && waited < 200) begin
         tick();
         waited++;
      end
      checkOutput("reach_release_011", int'(waited < 200), 1);
      applyReset();

      // Random LOCKED activity with sparse RESTART pulses.
      locked = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) locked = ~locked;
         restart = ($urandom_range(0, 99) == 0);
         tick();
      end
      restart = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
